eth_tx_fcs_ctrl: RTL and testbench
==================================

# eth_tx_fcs_ctrl

Transmit-side frame sequencer for the 32-bit MAC TX path. It sits between the frame source and the PCS and drives a `crc32` engine instance. That engine is configured with SLICE_LENGTH=4, INVERT_OUTPUT=1 and REGISTER_OUTPUT=1, and shares `clk` and `rst` with this block. The sequencer feeds frame bytes to the engine, zero-pads short frames, appends the 4-byte FCS after the last byte, and resets the engine between frames.

## Interface
- MIN_FRAME_BYTES, 60, minimum frame length before FCS; multiple of 4, ≥4.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- s_data  in  32  input frame beat; lane 0 (bits 7:0) is first on the wire.
- s_keep  in  4  valid lanes. Must be 4'hF on non-last beats. On the last beat it is contiguous from lane 0 and never 0.
- s_last  in  1  marks the last beat of the frame.
- s_valid / s_ready  in / out  1  input handshake.
- m_data, m_keep, m_last  out  32, 4, 1  output beat; same lane conventions as the input.
- m_valid / m_ready  out / in  1  output handshake.
- crc_data  out  32  bytes to the engine; unused lanes are forced to 0.
- crc_valid  out  4  engine lane valids.
- crc_reset  out  1  one-cycle engine reset.
- crc_value  in  32  engine output (the final FCS once the frame is fed).

## Operation
- **States:** DATA, PAD, FCS_A, FCS_B. Reset state is DATA.
- **Output register:** m_data/m_keep/m_last/m_valid are all registered. "free" = !m_valid || m_ready.
- **Byte counter:** cnt is a per-frame byte counter, $clog2(MIN_FRAME_BYTES)+1 bits, saturating at MIN_FRAME_BYTES. It clears when beat B is loaded.
- **Tail registers:** tail_reg (32 bits) and tail_k (3 bits) hold the final data beat, which is never output directly.
- **s_ready:** equals (state==DATA) && free.
- **DATA, accepted beat, s_last=0:** load the output register with the beat (keep F). Feed the engine with crc_data=s_data, crc_valid=4'hF. cnt += 4.
- **DATA, accepted beat, s_last=1, k=popcount(s_keep):**
  - cnt+k ≥ MIN: tail_reg←beat, tail_k←k, crc_valid=s_keep, clear m_valid, go to FCS_A.
  - cnt+k < MIN and cnt+4 == MIN: tail_reg←zero-filled beat, tail_k←4, crc_valid=F with zero-filled data, go to FCS_A.
  - Otherwise: output the zero-filled beat (keep F), crc_valid=F, cnt += 4, go to PAD.
- **PAD, each cycle the output register is free:** crc_data=0, crc_valid=F.
  - If cnt+4 == MIN: tail_reg←0, tail_k←4, clear m_valid, go to FCS_A.
  - Otherwise: output a zero beat, cnt += 4.
- **FCS byte order:** F0..F3 are crc_value[7:0], [15:8], [23:16], [31:24], in that order.
- **FCS_A, when free:** load beat A, keep F, last 0, then go to FCS_B.
  - Lanes 0..k-1 carry tail_reg.
  - Lanes k..3 carry F0..F(3-k).
- **FCS_B, when free:** load beat B, then go to DATA.
  - Lanes 0..k-1 carry F(4-k)..F3; remaining lanes are 0.
  - keep = (1<<k)-1, last 1.
  - Assert crc_reset in that same cycle.
- **crc_valid** is 0 in every cycle not listed above. crc_reset is 0 otherwise.
- **Frame length:** every output frame is ≥ MIN+4 bytes and always ends with beat A followed by beat B.

## Timing
- **Reset values:** while rst=0, m_valid, m_data, m_keep, m_last, crc_valid and crc_reset are all 0, state is DATA and cnt is 0. s_ready=1 after reset. The engine resets itself on the shared rst.
- **Non-tail latency:** a non-tail input beat appears on m_* one cycle after acceptance.
- **crc_value timing:** crc_value is valid in the first FCS_A cycle and stays stable through FCS_B, because no feeds occur in those states.
- **Beat A latency:** beat A is presented no earlier than the second edge after the last beat is accepted, leaving one bubble cycle.
- **Stall rule:** m_* must hold stable while m_valid && !m_ready.
- **Input blocking:** s_ready=0 in PAD, FCS_A and FCS_B.
- **Back-to-back frames:** the next frame can be accepted in the cycle after beat B is loaded, provided the output register is free.
- **Asynchronous reset mid-frame** (any state): the partial frame is dropped with no m_last. The next frame is processed correctly.

## Test plan
- **Reset:** assert rst mid-stream → all m_*/crc_* outputs are 0 immediately and s_ready=1 after release. The next frame is bit-exact.
- **Known CRC, MIN=4:** send "123456789" as beats 0x34333231, 0x38373635, and 0x39 with keep 0001, m_ready=1 → outputs 0x34333231, 0x38373635, then beat A 0xF4392639 (keep F), then beat B 0x000000CB (keep 0001, last=1).
- **Padding, MIN=60:** send a 1-byte frame 0xAB → first beat 0x000000AB, then zero beats, for 16 beats total. Every beat has keep F and only beat 16 has last=1. Beat 16 equals the model CRC-32 of the 60 padded bytes.
- **Full tail, MIN=60:** send bytes 0x00..0x3F (64 bytes, last keep F) → 16 data beats, then FCS as a full beat with keep F and last=1. The FCS matches the model.
- **Backpressure:** toggle m_ready 1,0,1,0 and hold s_valid → m_* stay stable while stalled, no data is lost or duplicated, and crc_valid is never asserted when s_ready=0 outside PAD.
- **Back-to-back frames:** send three frames with tail k=1, 2, 3 → each FCS is correct and crc_reset pulses exactly once per frame, in the beat B cycle.

Source files
------------

// File: rtl/eth_tx_fcs_ctrl.sv
// TX frame sequencer: forwards 32-bit beats, zero-pads short frames, feeds the CRC engine and appends the FCS.
// Non-tail beats appear one cycle after acceptance; s_ready drops while padding or emitting FCS, and m_* hold while stalled.
module eth_tx_fcs_ctrl #(
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic [3:0]  s_keep,
    input  logic        s_last,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_data,
    output logic [3:0]  m_keep,
    output logic        m_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] crc_data,
    output logic [3:0]  crc_valid,
    output logic        crc_reset,
    input  logic [31:0] crc_value
);
    localparam int CW = $clog2(MIN_FRAME_BYTES) + 1;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   cnt_e_t;
    localparam cnt_t   MIN_C = cnt_t'(MIN_FRAME_BYTES);
    localparam cnt_e_t MIN_E = cnt_e_t'(MIN_FRAME_BYTES);
    localparam cnt_e_t FOUR  = cnt_e_t'(4);

    typedef enum logic [1:0] {DATA, PAD, FCS_A, FCS_B} state_t;

    state_t      state, state_nxt;
    cnt_t        cnt, cnt_nxt;
    logic [31:0] tail_reg, tail_nxt;
    logic [2:0]  tail_k, tail_k_nxt;
    logic [31:0] m_data_nxt;
    logic [3:0]  m_keep_nxt;
    logic        m_last_nxt, m_valid_nxt;
    logic [31:0] crc_data_c;
    logic [3:0]  crc_valid_c;
    logic        crc_reset_c;
    logic        free;
    logic [2:0]  in_k;
    logic [31:0] s_zf;
    logic [31:0] beat_a, beat_b;
    logic [3:0]  keep_b;
    logic [1:0]  fcs_idx;
    cnt_e_t      cnt_e;

    function automatic cnt_t sat_add(input cnt_t c, input logic [2:0] n);
        cnt_e_t s;
        s = {1'b0, c} + cnt_e_t'(n);
        return (s >= MIN_E) ? MIN_C : s[CW-1:0];
    endfunction

    assign free    = !m_valid || m_ready;
    assign s_ready = rst && (state == DATA) && free;
    assign cnt_e   = {1'b0, cnt};

    always_comb begin
        case (s_keep)
            4'b0001: in_k = 3'd1;
            4'b0011: in_k = 3'd2;
            4'b0111: in_k = 3'd3;
            default: in_k = 3'd4;
        endcase
        s_zf = '0;
        for (int i = 0; i < 4; i++)
            if (s_keep[i]) s_zf[8*i +: 8] = s_data[8*i +: 8];
    end

    // Lane i of both FCS beats pulls FCS byte (i - k) mod 4, so one index serves A and B.
    always_comb begin
        beat_a  = '0;
        beat_b  = '0;
        keep_b  = '0;
        fcs_idx = '0;
        for (int i = 0; i < 4; i++) begin
            fcs_idx = 2'(i - int'(tail_k));
            if (i < int'(tail_k)) begin
                beat_a[8*i +: 8] = tail_reg[8*i +: 8];
                beat_b[8*i +: 8] = crc_value[8*fcs_idx +: 8];
                keep_b[i]        = 1'b1;
            end else begin
                beat_a[8*i +: 8] = crc_value[8*fcs_idx +: 8];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        tail_nxt    = tail_reg;
        tail_k_nxt  = tail_k;
        m_data_nxt  = m_data;
        m_keep_nxt  = m_keep;
        m_last_nxt  = m_last;
        m_valid_nxt = m_valid && !m_ready;
        crc_data_c  = '0;
        crc_valid_c = '0;
        crc_reset_c = 1'b0;
        case (state)
            DATA: if (free && s_valid) begin
                if (!s_last) begin
                    m_data_nxt  = s_data;
                    m_keep_nxt  = 4'hF;
                    m_last_nxt  = 1'b0;
                    m_valid_nxt = 1'b1;
                    crc_data_c  = s_data;
                    crc_valid_c = 4'hF;
                    cnt_nxt     = sat_add(cnt, 3'd4);
                end else if (cnt_e + cnt_e_t'(in_k) >= MIN_E) begin
                    tail_nxt    = s_zf;
                    tail_k_nxt  = in_k;
                    crc_data_c  = s_zf;
                    crc_valid_c = s_keep;
                    state_nxt   = FCS_A;
                end else if (cnt_e + FOUR == MIN_E) begin
                    tail_nxt    = s_zf;
                    tail_k_nxt  = 3'd4;
                    crc_data_c  = s_zf;
                    crc_valid_c = 4'hF;
                    state_nxt   = FCS_A;
                end else begin
                    m_data_nxt  = s_zf;
                    m_keep_nxt  = 4'hF;
                    m_last_nxt  = 1'b0;
                    m_valid_nxt = 1'b1;
                    crc_data_c  = s_zf;
                    crc_valid_c = 4'hF;
                    cnt_nxt     = sat_add(cnt, 3'd4);
                    state_nxt   = PAD;
                end
            end
            PAD: if (free) begin
                crc_valid_c = 4'hF;
                if (cnt_e + FOUR == MIN_E) begin
                    tail_nxt   = '0;
                    tail_k_nxt = 3'd4;
                    state_nxt  = FCS_A;
                end else begin
                    m_data_nxt  = '0;
                    m_keep_nxt  = 4'hF;
                    m_last_nxt  = 1'b0;
                    m_valid_nxt = 1'b1;
                    cnt_nxt     = sat_add(cnt, 3'd4);
                end
            end
            FCS_A: if (free) begin
                m_data_nxt  = beat_a;
                m_keep_nxt  = 4'hF;
                m_last_nxt  = 1'b0;
                m_valid_nxt = 1'b1;
                state_nxt   = FCS_B;
            end
            FCS_B: if (free) begin
                m_data_nxt  = beat_b;
                m_keep_nxt  = keep_b;
                m_last_nxt  = 1'b1;
                m_valid_nxt = 1'b1;
                crc_reset_c = 1'b1;
                cnt_nxt     = '0;
                state_nxt   = DATA;
            end
            default: state_nxt = DATA;
        endcase
    end

    // Engine strobes are combinational so the final FCS is ready in the first FCS_A cycle.
    assign crc_data  = rst ? crc_data_c  : '0;
    assign crc_valid = rst ? crc_valid_c : '0;
    assign crc_reset = rst && crc_reset_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DATA;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            tail_reg <= '0;
            tail_k   <= '0;
            m_data   <= '0;
            m_keep   <= '0;
            m_last   <= 1'b0;
            m_valid  <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            tail_reg <= tail_nxt;
            tail_k   <= tail_k_nxt;
            m_data   <= m_data_nxt;
            m_keep   <= m_keep_nxt;
            m_last   <= m_last_nxt;
            m_valid  <= m_valid_nxt;
        end
    end
endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Bench for eth_tx_fcs_ctrl: instance 0 uses MIN_FRAME_BYTES=4, instance 1 uses 60, each with a CRC-32 engine stand-in.
module tb_eth_tx_fcs_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic [31:0] s_data [2];
    logic [3:0]  s_keep [2];
    logic [1:0]  s_last;
    logic [1:0]  s_valid;
    logic [1:0]  m_ready = 2'b11;
    wire  [1:0]  s_ready, m_last, m_valid, crc_reset;
    wire  [31:0] m_data [2];
    wire  [3:0]  m_keep [2];
    wire  [31:0] crc_data [2];
    wire  [3:0]  crc_valid [2];
    wire  [31:0] crc_value [2];

    int checks = 0;
    int errors = 0;
    int sel = 0;
    int rdy_mode = 0;
    int rx_beats = 0;
    int crc_resets = 0;
    logic mon_en = 1'b1;
    beat_t exp_q [$];
    logic [7:0] frm [$];

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] crc_feed(input logic [31:0] c, input logic [31:0] d, input logic [3:0] v);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++)
            if (v[i]) r = crc_byte(r, d[8*i +: 8]);
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [31:0] eng;
        eth_tx_fcs_ctrl #(.MIN_FRAME_BYTES(g == 0 ? 4 : 60)) u_dut (
            .clk(clk), .rst(rst),
            .s_data(s_data[g]), .s_keep(s_keep[g]), .s_last(s_last[g]),
            .s_valid(s_valid[g]), .s_ready(s_ready[g]),
            .m_data(m_data[g]), .m_keep(m_keep[g]), .m_last(m_last[g]),
            .m_valid(m_valid[g]), .m_ready(m_ready[g]),
            .crc_data(crc_data[g]), .crc_valid(crc_valid[g]),
            .crc_reset(crc_reset[g]), .crc_value(crc_value[g])
        );
        always @(posedge clk or negedge rst)
            if (!rst)              eng <= 32'hFFFF_FFFF;
            else if (crc_reset[g]) eng <= 32'hFFFF_FFFF;
            else                   eng <= crc_feed(eng, crc_data[g], crc_valid[g]);
        assign crc_value[g] = ~eng;
    end

    // Sink ready pattern for the selected instance; the idle one always accepts.
    initial forever begin
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++)
            if (u != sel || rdy_mode == 0) m_ready[u] = 1'b1;
            else                           m_ready[u] = ~m_ready[u];
    end

    // Output monitor: scoreboard pop, stall hold and idle-feed rules.
    initial begin
        logic stalled;
        logic [36:0] held;
        beat_t e;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst || !mon_en) begin
                stalled = 1'b0;
            end else begin
                if (m_valid[sel] && m_ready[sel]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected got data=%h keep=%b last=%b required no beat",
                                 m_data[sel], m_keep[sel], m_last[sel]);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_data[sel], m_keep[sel], m_last[sel]} !== e) begin
                            errors++;
                            $display("FAIL beat got data=%h keep=%b last=%b required data=%h keep=%b last=%b",
                                     m_data[sel], m_keep[sel], m_last[sel], e.d, e.k, e.l);
                        end
                    end
                    rx_beats++;
                end
                if (stalled) begin
                    checks++;
                    if ({m_data[sel], m_keep[sel], m_last[sel], m_valid[sel]} !== {held, 1'b1}) begin
                        errors++;
                        $display("FAIL stall_hold got %h/%b/%b valid=%b required %h held",
                                 m_data[sel], m_keep[sel], m_last[sel], m_valid[sel], held);
                    end
                end
                stalled = m_valid[sel] && !m_ready[sel];
                held = {m_data[sel], m_keep[sel], m_last[sel]};
                if ((m_valid[sel] && !m_ready[sel]) || (s_ready[sel] && !s_valid[sel])) begin
                    checks++;
                    if (crc_valid[sel] !== 4'h0) begin
                        errors++;
                        $display("FAIL crc_valid_idle got %b required 0000", crc_valid[sel]);
                    end
                end
                if (crc_reset[sel] === 1'b1) crc_resets++;
            end
        end
    end

    task automatic send_beat(input int u, input logic [31:0] d, input logic [3:0] k, input logic l);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        s_data[u] = d;
        s_keep[u] = k;
        s_last[u] = l;
        s_valid[u] = 1'b1;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = s_ready[u];
            @(posedge clk);
            #1;
            n++;
        end
        s_valid[u] = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got no s_ready required acceptance within 500 cycles");
        end
    endtask

    task automatic send_frame(input int u);
        int nb;
        logic [31:0] d;
        logic [3:0] k;
        nb = frm.size();
        for (int i = 0; i < nb; i += 4) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 4; j++)
                if (i + j < nb) begin
                    d[8*j +: 8] = frm[i+j];
                    k[j] = 1'b1;
                end
            send_beat(u, d, k, (i + 4 >= nb));
        end
    endtask

    // Reference output stream: frame zero-padded to min bytes, then the 4 FCS bytes LSB first.
    task automatic push_model(input int min);
        logic [7:0] p [$];
        logic [31:0] c;
        beat_t e;
        p = frm;
        while (p.size() < min) p.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < p.size(); i++) c = crc_byte(c, p[i]);
        c = ~c;
        for (int j = 0; j < 4; j++) p.push_back(c[8*j +: 8]);
        for (int i = 0; i < p.size(); i += 4) begin
            e = '0;
            for (int j = 0; j < 4; j++)
                if (i + j < p.size()) begin
                    e.d[8*j +: 8] = p[i+j];
                    e.k[j] = 1'b1;
                end
            e.l = (i + 4 >= p.size());
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_frame(input int len, input int mode);
        frm.delete();
        for (int i = 0; i < len; i++)
            frm.push_back(mode == 0 ? 8'(i) : 8'($urandom_range(0, 255)));
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d beats pending required 0", nm, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({m_valid[u], m_last[u], m_keep[u], m_data[u], crc_valid[u], crc_reset[u]} !== '0) begin
                errors++;
                $display("FAIL reset_state u=%0d got valid=%b data=%h keep=%b crc_valid=%b crc_reset=%b required all 0",
                         u, m_valid[u], m_data[u], m_keep[u], crc_valid[u], crc_reset[u]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (s_ready[u] !== 1'b1 || m_valid[u] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release u=%0d got s_ready=%b m_valid=%b required 1/0", u, s_ready[u], m_valid[u]);
            end
        end
    endtask

    task automatic test_known_crc;
        sel = 0;
        exp_q.push_back({32'h3433_3231, 4'hF, 1'b0});
        exp_q.push_back({32'h3837_3635, 4'hF, 1'b0});
        exp_q.push_back({32'hF439_2639, 4'hF, 1'b0});
        exp_q.push_back({32'h0000_00CB, 4'h1, 1'b1});
        send_beat(0, 32'h3433_3231, 4'hF, 1'b0);
        checks++;
        if (m_valid[0] !== 1'b1 || m_data[0] !== 32'h3433_3231) begin
            errors++;
            $display("FAIL known_latency got valid=%b data=%h required 1/34333231", m_valid[0], m_data[0]);
        end
        send_beat(0, 32'h3837_3635, 4'hF, 1'b0);
        send_beat(0, 32'h0000_0039, 4'h1, 1'b1);
        checks++;
        if (m_valid[0] !== 1'b0 || s_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL known_bubble got m_valid=%b s_ready=%b required 0/0", m_valid[0], s_ready[0]);
        end
        drain("known_crc");
    endtask

    task automatic test_frame_beats(input string nm, input int len, input int exp_beats);
        int rx0, cr0;
        sel = 1;
        rx0 = rx_beats;
        cr0 = crc_resets;
        fill_frame(len, 0);
        if (len == 1) frm[0] = 8'hAB;
        push_model(60);
        send_frame(1);
        drain(nm);
        checks++;
        if (rx_beats - rx0 != exp_beats || crc_resets - cr0 != 1) begin
            errors++;
            $display("FAIL %s_count got beats=%0d crc_resets=%0d required %0d/1",
                     nm, rx_beats - rx0, crc_resets - cr0, exp_beats);
        end
    endtask

    task automatic test_backpressure;
        sel = 1;
        rdy_mode = 1;
        fill_frame(10, 1);
        push_model(60);
        send_frame(1);
        fill_frame(70, 1);
        push_model(60);
        send_frame(1);
        drain("backpressure");
        rdy_mode = 0;
        sel = 0;
        rdy_mode = 1;
        fill_frame(7, 1);
        push_model(4);
        send_frame(0);
        drain("backpressure_min4");
        rdy_mode = 0;
    endtask

    task automatic test_back_to_back;
        int cr0;
        sel = 1;
        cr0 = crc_resets;
        fill_frame(61, 1); push_model(60); send_frame(1);
        fill_frame(66, 1); push_model(60); send_frame(1);
        fill_frame(63, 1); push_model(60); send_frame(1);
        drain("back_to_back");
        checks++;
        if (crc_resets - cr0 != 3) begin
            errors++;
            $display("FAIL b2b_crc_reset got %0d pulses required 3", crc_resets - cr0);
        end
    endtask

    task automatic test_reset_mid;
        int cr0;
        sel = 1;
        mon_en = 1'b0;
        frm.delete();
        frm.push_back(8'hAB);
        send_frame(1);
        @(posedge clk);
        #1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({m_valid[1], m_last[1], m_keep[1], m_data[1], crc_valid[1], crc_reset[1]} !== '0) begin
            errors++;
            $display("FAIL reset_mid u=1 got valid=%b data=%h keep=%b crc_valid=%b crc_reset=%b required all 0",
                     m_valid[1], m_data[1], m_keep[1], crc_valid[1], crc_reset[1]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready got %b required 1", s_ready[1]);
        end
        exp_q.delete();
        mon_en = 1'b1;
        cr0 = crc_resets;
        fill_frame(13, 1);
        push_model(60);
        send_frame(1);
        drain("after_reset");
        checks++;
        if (crc_resets - cr0 != 1) begin
            errors++;
            $display("FAIL after_reset_crc_reset got %0d pulses required 1", crc_resets - cr0);
        end
    endtask

    initial begin
        s_valid = '0;
        s_last = '0;
        for (int u = 0; u < 2; u++) begin
            s_data[u] = '0;
            s_keep[u] = '0;
        end
        test_reset();
        test_known_crc();
        test_frame_beats("padding", 1, 16);
        test_frame_beats("full_tail", 64, 17);
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
